// File: rtl/rx_pkg.sv
// rx_pkg: shared state codes, FSM encoding, header defaults and pixel width
// for the UART receive pixel packer.
package rx_pkg;

  localparam logic [7:0] ST_IDLE  = 8'h01;
  localparam logic [7:0] ST_RECV  = 8'h02;
  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;
  localparam int         PIX_W    = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } fsm_t;

endpackage

// File: rtl/rx_idle_timer.sv
// rx_idle_timer: counts enabled cycles without a clear and pulses expire on
// the TIMEOUT_CYC-th such cycle; a clear in that same cycle suppresses expiry.
module rx_idle_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  assign expire = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_pixel_packer.sv
// rx_pixel_packer: hunts the two-byte header, packs payload bytes 3->2 into RGB444
// pixels with an idle timeout. Define PACKER_CHKSUM_EN for a trailing XOR checksum byte.
module rx_pixel_packer
  import rx_pkg::*;
#(
  parameter int          PIX_TOTAL   = 20480,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter int          TIMEOUT_CYC = 500000
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic [7:0]       o_state,
  output logic             o_rx_valid,
  output logic [PIX_W-1:0] o_rx_data,
  output logic [14:0]      o_pix_cnt,
  output logic             o_frame_done,
  output logic             o_err
);

  localparam logic [14:0] LAST_PIX = 15'(PIX_TOTAL - 1);

  fsm_t       state, state_nxt;
  logic [1:0] phase;
  logic [7:0] hold_byte;
  logic [3:0] hold_nib;
  logic       tmr_en, tmr_expire, last_pix;
`ifdef PACKER_CHKSUM_EN
  logic [7:0] chk_acc;
`endif

  assign last_pix = (phase != 2'd0) && (o_pix_cnt == LAST_PIX);
  assign tmr_en   = (state == PAY) || (state == CHK);

  rx_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (i_clk_sys),
    .rst_n  (i_rst_n),
    .clear  (i_byte_valid),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_nxt = state;
    if (i_byte_valid) begin
      case (state)
        IDLE: if (i_byte == HDR0) state_nxt = HDR;
        HDR: begin
          if (i_byte == HDR1)      state_nxt = PAY;
          else if (i_byte == HDR0) state_nxt = HDR;
          else                     state_nxt = IDLE;
        end
        PAY: begin
          if (last_pix) begin
`ifdef PACKER_CHKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = IDLE;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmr_expire) begin
      state_nxt = IDLE;
    end
  end

  // o_state is decoded from the next state so it lines up with the state register.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_state <= ST_IDLE;
    end else begin
      state   <= state_nxt;
      o_state <= (state_nxt == PAY || state_nxt == CHK) ? ST_RECV : ST_IDLE;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase        <= 2'd0;
      hold_byte    <= 8'd0;
      hold_nib     <= 4'd0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_pix_cnt    <= 15'd0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
`ifdef PACKER_CHKSUM_EN
      chk_acc      <= 8'd0;
`endif
    end else begin
      o_rx_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      if (i_byte_valid && state == HDR && i_byte == HDR1) begin
        phase     <= 2'd0;
        o_pix_cnt <= 15'd0;
`ifdef PACKER_CHKSUM_EN
        chk_acc   <= 8'd0;
`endif
      end else if (i_byte_valid && state == PAY) begin
`ifdef PACKER_CHKSUM_EN
        chk_acc <= chk_acc ^ i_byte;
`endif
        case (phase)
          2'd0: begin
            hold_byte <= i_byte;
            phase     <= 2'd1;
          end
          2'd1: begin
            o_rx_data  <= {hold_byte, i_byte[7:4]};
            hold_nib   <= i_byte[3:0];
            phase      <= 2'd2;
            o_rx_valid <= 1'b1;
            o_pix_cnt  <= o_pix_cnt + 15'd1;
          end
          default: begin
            o_rx_data  <= {hold_nib, i_byte};
            phase      <= 2'd0;
            o_rx_valid <= 1'b1;
            o_pix_cnt  <= o_pix_cnt + 15'd1;
          end
        endcase
`ifndef PACKER_CHKSUM_EN
        if (last_pix) o_frame_done <= 1'b1;
`endif
`ifdef PACKER_CHKSUM_EN
      end else if (i_byte_valid && state == CHK) begin
        if (i_byte == chk_acc) o_frame_done <= 1'b1;
        else                   o_err        <= 1'b1;
`endif
      end else if (tmr_expire) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_pixel_packer.sv
// tb_rx_pixel_packer: drives two packers (4 and 3 pixels/frame, timeout 50) with
// directed and random byte streams against a frame-level behavioural model.
module tb_rx_pixel_packer;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv = 1'b0;
  logic [7:0]  bt = 8'd0;

  logic [7:0]  dut_state [2];
  logic        dut_valid [2];
  logic [11:0] dut_data  [2];
  logic [14:0] dut_cnt   [2];
  logic        dut_done  [2];
  logic        dut_err   [2];

  int n_checks = 0;
  int n_fails  = 0;

  // Frame-level model: mode 0 hunt, 1 saw first header byte, 2 payload, 3 checksum.
  int          m_tot  [2] = '{4, 3};
  int          m_mode [2];
  int          m_n    [2];
  int          m_idle [2];
  logic [7:0]  m_pay  [2][8];
  logic [7:0]  e_st   [2];
  logic        e_v    [2];
  logic [11:0] e_d    [2];
  logic [14:0] e_c    [2];
  logic        e_done [2];
  logic        e_err  [2];

  always #5 clk = ~clk;

  rx_pixel_packer #(.PIX_TOTAL(4), .TIMEOUT_CYC(TMO)) u_pack4 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_byte_valid(bv), .i_byte(bt),
    .o_state(dut_state[0]), .o_rx_valid(dut_valid[0]), .o_rx_data(dut_data[0]),
    .o_pix_cnt(dut_cnt[0]), .o_frame_done(dut_done[0]), .o_err(dut_err[0])
  );

  rx_pixel_packer #(.PIX_TOTAL(3), .TIMEOUT_CYC(TMO)) u_pack3 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_byte_valid(bv), .i_byte(bt),
    .o_state(dut_state[1]), .o_rx_valid(dut_valid[1]), .o_rx_data(dut_data[1]),
    .o_pix_cnt(dut_cnt[1]), .o_frame_done(dut_done[1]), .o_err(dut_err[1])
  );

  function automatic int pix_of(int n);
    return (2 * n) / 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("u%0d.state", i), 32'(dut_state[i]), 32'(e_st[i]));
      checkOutput($sformatf("u%0d.valid", i), 32'(dut_valid[i]), 32'(e_v[i]));
      checkOutput($sformatf("u%0d.data", i),  32'(dut_data[i]),  32'(e_d[i]));
      checkOutput($sformatf("u%0d.cnt", i),   32'(dut_cnt[i]),   32'(e_c[i]));
      checkOutput($sformatf("u%0d.done", i),  32'(dut_done[i]),  32'(e_done[i]));
      checkOutput($sformatf("u%0d.err", i),   32'(dut_err[i]),   32'(e_err[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_n[i] = 0; m_idle[i] = 0;
      for (int k = 0; k < 8; k++) m_pay[i][k] = 8'd0;
      e_st[i] = 8'h01; e_v[i] = 1'b0; e_d[i] = 12'd0; e_c[i] = 15'd0;
      e_done[i] = 1'b0; e_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int p, g;
    logic [23:0] w;
    logic [7:0]  x;
    for (int i = 0; i < 2; i++) begin
      e_v[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
      case (m_mode[i])
        0: if (v && b == 8'hA5) m_mode[i] = 1;
        1: if (v) begin
          if (b == 8'h5A) begin
            m_mode[i] = 2; m_n[i] = 0; m_idle[i] = 0; e_c[i] = 15'd0;
          end else if (b != 8'hA5) begin
            m_mode[i] = 0;
          end
        end
        default: begin
          if (!v) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin
              e_err[i] = 1'b1; m_mode[i] = 0;
            end
          end else begin
            m_idle[i] = 0;
            if (m_mode[i] == 2) begin
              m_pay[i][m_n[i]] = b;
              m_n[i]++;
              if (pix_of(m_n[i]) > pix_of(m_n[i] - 1)) begin
                p = pix_of(m_n[i]) - 1;
                g = p / 2;
                w = {m_pay[i][3*g], m_pay[i][3*g+1], m_pay[i][3*g+2]};
                e_d[i] = (p % 2 == 0) ? w[23:12] : w[11:0];
                e_v[i] = 1'b1;
                e_c[i] = 15'(pix_of(m_n[i]));
                if (pix_of(m_n[i]) == m_tot[i]) begin
`ifdef PACKER_CHKSUM_EN
                  m_mode[i] = 3;
`else
                  m_mode[i] = 0; e_done[i] = 1'b1;
`endif
                end
              end
            end else begin
              x = 8'd0;
              for (int k = 0; k < m_n[i]; k++) x = x ^ m_pay[i][k];
              if (x == b) e_done[i] = 1'b1;
              else        e_err[i]  = 1'b1;
              m_mode[i] = 0;
            end
          end
        end
      endcase
      e_st[i] = (m_mode[i] >= 2) ? 8'h02 : 8'h01;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b);
    bv = v; bt = b;
    @(posedge clk);
    model_step(v, b);
    @(negedge clk);
    check_all();
    bv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    applyStimulus(1'b1, b);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic send_list(input logic [7:0] seq [$]);
    foreach (seq[k]) send_byte(seq[k]);
  endtask

  initial begin
    logic [7:0] x;
    int gap, r;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic frame.
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55});
    checkOutput("t1.p0", 32'(dut_data[0]), 32'h375);
    send_list('{8'h35, 8'h29, 8'h93, 8'h15});
    checkOutput("t1.p3", 32'(dut_data[0]), 32'h315);
    checkOutput("t1.cnt", 32'(dut_cnt[0]), 32'd4);
    idle_cycles(TMO + 5);

`ifdef PACKER_CHKSUM_EN
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55, 8'h35, 8'h29, 8'h93, 8'h15, 8'hF8});
    checkOutput("t2.done", 32'(dut_done[0]), 32'd1);
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55, 8'h35, 8'h29, 8'h93, 8'h15, 8'hF7});
    checkOutput("t2.err", 32'(dut_err[0]), 32'd1);
    idle_cycles(TMO + 5);
`endif

    // Header hunt.
    send_list('{8'h12, 8'hA5, 8'hA5, 8'h5A, 8'h37, 8'h55, 8'h35});
    idle_cycles(TMO + 5);
    send_list('{8'h33, 8'h5A, 8'h37});
    checkOutput("t3.state", 32'(dut_state[0]), 32'h01);

    // Timeout, then a byte landing on the last idle cycle.
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55});
    idle_cycles(TMO);
    checkOutput("t4.err", 32'(dut_err[0]), 32'd1);
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55});
    idle_cycles(TMO - 1);
    send_list('{8'h35, 8'h29, 8'h93, 8'h15});
    idle_cycles(TMO + 5);

    // Odd frame length on the 3-pixel instance.
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55, 8'h35, 8'h29, 8'h9F});
    checkOutput("t5.p2", 32'(dut_data[1]), 32'h299);
    idle_cycles(TMO + 5);

    // Asynchronous reset mid-frame.
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55});
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    send_list('{8'hA5, 8'h5A, 8'h37, 8'h55, 8'h35, 8'h29, 8'h93, 8'h15});
    idle_cycles(TMO + 5);

    // Random frames with noise, gaps and occasional timeouts.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_byte(8'($urandom));
      send_byte(8'hA5);
      send_byte(8'h5A);
      x = 8'd0;
      for (int k = 0; k < 6; k++) begin
        r = int'($urandom_range(0, 19));
        gap = (r < 14) ? 0 : (r < 17) ? int'($urandom_range(1, 4)) : (r == 17) ? TMO - 1 : TMO;
        idle_cycles(gap);
        bt = 8'($urandom);
        x = x ^ bt;
        send_byte(bt);
      end
`ifdef PACKER_CHKSUM_EN
      send_byte(($urandom_range(0, 1) == 0) ? x : (x ^ 8'h01));
`endif
      idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(TMO + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
